// File: rtl/xor_boh.sv
// rtl/xor_boh.sv - single-bit XOR sum cell with registered copy, running parity and saturating ones count
// The combinational sum never depends on clk/rst; the clocked outputs are optional observability.
module xor_boh #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             a,
   input  logic             b,
   input  logic             clr,
   output logic             s,
   output logic             s_q,
   output logic             parity,
   output logic [CNT_W-1:0] ones_cnt
);

   logic             w_s;
   logic             w_cnt_sat;
   logic             r_s_q;
   logic             r_parity;
   logic [CNT_W-1:0] r_ones_cnt;

   assign w_s       = a ^ b;
   assign w_cnt_sat = &r_ones_cnt;

   // clr wins over the normal update, so the sum sampled on a clear edge is discarded
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s_q      <= 1'b0;
         r_parity   <= 1'b0;
         r_ones_cnt <= '0;
      end else if (clr) begin
         r_s_q      <= 1'b0;
         r_parity   <= 1'b0;
         r_ones_cnt <= '0;
      end else begin
         r_s_q    <= w_s;
         r_parity <= r_parity ^ w_s;
         if (w_s && !w_cnt_sat)
            r_ones_cnt <= r_ones_cnt + CNT_W'(1);
      end
   end

   assign s        = w_s;
   assign s_q      = r_s_q;
   assign parity   = r_parity;
   assign ones_cnt = r_ones_cnt;

endmodule

// File: tb/tb_xor_boh.sv
// tb/tb_xor_boh.sv - directed self-checking bench for xor_boh
// A default-width and a 3-bit-counter instance share the same stimulus.
module tb_xor_boh;

   logic       clk = 1'b0;
   logic       clk_en = 1'b0;
   logic       rst, a, b, clr;
   logic       s8, s_q8, par8;
   logic [7:0] cnt8;
   logic       s3, s_q3, par3;
   logic [2:0] cnt3;

   int n_checks = 0;
   int n_fail   = 0;

   xor_boh #(.CNT_W(8)) dut8 (
      .clk(clk), .rst(rst), .a(a), .b(b), .clr(clr),
      .s(s8), .s_q(s_q8), .parity(par8), .ones_cnt(cnt8)
   );

   xor_boh #(.CNT_W(3)) dut3 (
      .clk(clk), .rst(rst), .a(a), .b(b), .clr(clr),
      .s(s3), .s_q(s_q3), .parity(par3), .ones_cnt(cnt3)
   );

   always begin
      #5;
      if (clk_en) clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; clr = 1'b0; a = 1'b0; b = 1'b0;
      #1;
      n_checks++;
      if ({s_q8, par8, cnt8} !== 10'd0) begin
         n_fail++;
         $display("FAIL reset_state8 got s_q=%b par=%b cnt=%0d want 0/0/0", s_q8, par8, cnt8);
      end
      n_checks++;
      if ({s_q3, par3, cnt3} !== 5'd0) begin
         n_fail++;
         $display("FAIL reset_state3 got s_q=%b par=%b cnt=%0d want 0/0/0", s_q3, par3, cnt3);
      end
   endtask

   task automatic test_truth_table();
      logic [1:0] vec [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
      logic       exp [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
      for (int i = 0; i < 4; i++) begin
         {a, b} = vec[i];
         #1;
         n_checks++;
         if (s8 !== exp[i] || s3 !== exp[i]) begin
            n_fail++;
            $display("FAIL truth_table ab=%b got s=%b/%b want %b", vec[i], s8, s3, exp[i]);
         end
      end
   endtask

   task automatic test_async_reset();
      a = 1'b1; b = 1'b0;
      rst = 1'b0;
      clk_en = 1'b1;
      tick(); tick(); tick();
      n_checks++;
      if (cnt8 !== 8'd3 || par8 !== 1'b1 || s_q8 !== 1'b1) begin
         n_fail++;
         $display("FAIL pre_reset_run got cnt=%0d par=%b s_q=%b want 3/1/1", cnt8, par8, s_q8);
      end
      #2 rst = 1'b1;
      #1;
      n_checks++;
      if ({s_q8, par8, cnt8} !== 10'd0 || {s_q3, par3, cnt3} !== 5'd0) begin
         n_fail++;
         $display("FAIL async_reset got s_q=%b par=%b cnt=%0d want 0/0/0", s_q8, par8, cnt8);
      end
      n_checks++;
      if (s8 !== 1'b1) begin
         n_fail++;
         $display("FAIL s_during_reset got %b want 1", s8);
      end
      tick();
      n_checks++;
      if ({s_q8, par8, cnt8} !== 10'd0) begin
         n_fail++;
         $display("FAIL reset_hold got s_q=%b par=%b cnt=%0d want 0/0/0", s_q8, par8, cnt8);
      end
      rst = 1'b0;
   endtask

   task automatic test_registered();
      logic [1:0] vec  [4] = '{2'b01, 2'b11, 2'b10, 2'b00};
      logic       e_sq [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
      logic       e_par[4] = '{1'b1, 1'b1, 1'b0, 1'b0};
      logic [7:0] e_cnt[4] = '{8'd1, 8'd1, 8'd2, 8'd2};
      for (int i = 0; i < 4; i++) begin
         {a, b} = vec[i];
         tick();
         n_checks++;
         if (s_q8 !== e_sq[i] || par8 !== e_par[i] || cnt8 !== e_cnt[i]) begin
            n_fail++;
            $display("FAIL registered step%0d got s_q=%b par=%b cnt=%0d want %b/%b/%0d",
                     i, s_q8, par8, cnt8, e_sq[i], e_par[i], e_cnt[i]);
         end
      end
   endtask

   task automatic test_clear();
      a = 1'b1; b = 1'b0; clr = 1'b1;
      tick();
      n_checks++;
      if ({s_q8, par8, cnt8} !== 10'd0) begin
         n_fail++;
         $display("FAIL clear_priority got s_q=%b par=%b cnt=%0d want 0/0/0", s_q8, par8, cnt8);
      end
      clr = 1'b0;
      tick();
      n_checks++;
      if (s_q8 !== 1'b1 || par8 !== 1'b1 || cnt8 !== 8'd1) begin
         n_fail++;
         $display("FAIL after_clear got s_q=%b par=%b cnt=%0d want 1/1/1", s_q8, par8, cnt8);
      end
   endtask

   task automatic test_saturation();
      logic [2:0] e_cnt;
      clr = 1'b1;
      tick();
      clr = 1'b0;
      a = 1'b0; b = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         tick();
         e_cnt = (i > 7) ? 3'd7 : 3'(i);
         n_checks++;
         if (cnt3 !== e_cnt || par3 !== 1'(i % 2)) begin
            n_fail++;
            $display("FAIL saturation edge%0d got cnt=%0d par=%b want %0d/%b",
                     i, cnt3, par3, e_cnt, 1'(i % 2));
         end
      end
      n_checks++;
      if (cnt8 !== 8'd10) begin
         n_fail++;
         $display("FAIL wide_count got %0d want 10", cnt8);
      end
   endtask

   task automatic test_rst_clr_collision();
      a = 1'b1; b = 1'b1;
      rst = 1'b1; clr = 1'b1;
      tick();
      n_checks++;
      if ({s_q8, par8, cnt8} !== 10'd0 || {s_q3, par3, cnt3} !== 5'd0) begin
         n_fail++;
         $display("FAIL collision got s_q=%b par=%b cnt=%0d want 0/0/0", s_q8, par8, cnt8);
      end
      n_checks++;
      if (s8 !== 1'b0) begin
         n_fail++;
         $display("FAIL collision_s11 got %b want 0", s8);
      end
      a = 1'b0;
      #1;
      n_checks++;
      if (s8 !== 1'b1) begin
         n_fail++;
         $display("FAIL collision_s01 got %b want 1", s8);
      end
      rst = 1'b0; clr = 1'b0;
      tick();
      n_checks++;
      if (s_q8 !== 1'b1 || cnt8 !== 8'd1) begin
         n_fail++;
         $display("FAIL post_collision got s_q=%b cnt=%0d want 1/1", s_q8, cnt8);
      end
   endtask

   initial begin
      test_reset();
      test_truth_table();
      test_async_reset();
      test_registered();
      test_clear();
      test_saturation();
      test_rst_clr_collision();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
